// File: rtl/dcfir_pkg.sv
// Shared widths, sdi field layout and accumulator sizing for the parametrised complex FIR slave.
package dcfir_pkg;

  localparam int DW_DEF   = 16;
  localparam int CW_DEF   = 10;
  localparam int AW_DEF   = 4;
  localparam int SELW_DEF = 6;
  localparam int NTAP_DEF = 3;
  localparam int NTAP_MAX = 16;

  localparam int COE_LSB = 0;
  localparam int IM_BIT  = CW_DEF;
  localparam int TAP_LSB = CW_DEF + 1;

  function automatic int im_bit(input int cw);
    return cw;
  endfunction

  function automatic int tap_lsb(input int cw);
    return cw + 1;
  endfunction

  function automatic int clog2_int(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 6; i++) begin
      if ((32'sd1 <<< l) < n) begin
        l = l + 1;
      end else begin
        l = l;
      end
    end
    return l;
  endfunction

  // Sum of NTAP complex products (each DW+CW+1 bits) without overflow.
  function automatic int acc_width(input int dw, input int cw, input int ntap);
    return dw + cw + 1 + clog2_int(ntap);
  endfunction

endpackage

// File: rtl/d_cfir_slave_param_coe_bank.sv
// Shadow/active coefficient banks with serial sdi decode and deferred commit handling.
module dcfir_coe_bank
  import dcfir_pkg::*;
#(
  parameter int NTAP = NTAP_DEF,
  parameter int CW   = CW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ssb,
  input  logic [AW+CW:0]       sdi,
  input  logic                 coe_load,
  output logic                 coe_pending,
  output logic [NTAP*CW-1:0]   active_re,
  output logic [NTAP*CW-1:0]   active_im
);

  localparam int IMB  = im_bit(CW);
  localparam int TLSB = tap_lsb(CW);

  logic [CW-1:0] shadow_re_q [NTAP];
  logic [CW-1:0] shadow_re_d [NTAP];
  logic [CW-1:0] shadow_im_q [NTAP];
  logic [CW-1:0] shadow_im_d [NTAP];
  logic [CW-1:0] active_re_q [NTAP];
  logic [CW-1:0] active_re_d [NTAP];
  logic [CW-1:0] active_im_q [NTAP];
  logic [CW-1:0] active_im_d [NTAP];
  logic          pending_q;
  logic          pending_d;
  logic [AW-1:0] tap_s;
  logic          wr_ok_s;
  logic          commit_s;

  // Writes only happen with ssb=0 and commits only with ssb=1, so they never overlap.
  always_comb begin
    tap_s     = sdi[TLSB +: AW];
    wr_ok_s   = !ssb && (32'(tap_s) < 32'(NTAP));
    commit_s  = ssb && (coe_load || pending_q);
    pending_d = !ssb && (coe_load || pending_q);
    for (int k = 0; k < NTAP; k++) begin
      shadow_re_d[k] = shadow_re_q[k];
      shadow_im_d[k] = shadow_im_q[k];
      if (wr_ok_s && (32'(tap_s) == 32'(k))) begin
        if (sdi[IMB]) begin
          shadow_im_d[k] = sdi[COE_LSB +: CW];
        end else begin
          shadow_re_d[k] = sdi[COE_LSB +: CW];
        end
      end else begin
        shadow_re_d[k] = shadow_re_q[k];
      end
      if (commit_s) begin
        active_re_d[k] = shadow_re_q[k];
        active_im_d[k] = shadow_im_q[k];
      end else begin
        active_re_d[k] = active_re_q[k];
        active_im_d[k] = active_im_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        shadow_re_q[k] <= '0;
        shadow_im_q[k] <= '0;
        active_re_q[k] <= '0;
        active_im_q[k] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int k = 0; k < NTAP; k++) begin
        shadow_re_q[k] <= shadow_re_d[k];
        shadow_im_q[k] <= shadow_im_d[k];
        active_re_q[k] <= active_re_d[k];
        active_im_q[k] <= active_im_d[k];
      end
    end
  end

  always_comb begin
    coe_pending = pending_q;
    for (int k = 0; k < NTAP; k++) begin
      active_re[k*CW +: CW] = active_re_q[k];
      active_im[k*CW +: CW] = active_im_q[k];
    end
  end

endmodule

// File: rtl/d_cfir_slave_param.sv
// Parametrised 4-stage complex FIR slave with double-buffered coefficients.
// Define DCFIR_SAT_EN to saturate the output; otherwise the low DW bits are kept.
module d_cfir_slave_param
  import dcfir_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int NTAP = NTAP_DEF,
  parameter int SELW = SELW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 ssb,
  input  logic [AW+CW:0]       sdi,
  input  logic                 coe_load,
  output logic                 coe_pending,
  input  logic [SELW-1:0]      sel,
  input  logic                 din_valid,
  input  logic [DW-1:0]        din_data_real,
  input  logic [DW-1:0]        din_data_imag,
  output logic                 dout_valid,
  output logic [DW-1:0]        output_real,
  output logic [DW-1:0]        output_img
);

  localparam int PW   = DW + CW;
  localparam int ACCW = acc_width(DW, CW, NTAP);
  localparam int RW   = ACCW + 1;

`ifdef DCFIR_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  function automatic logic [DW-1:0] reduce_s(input logic signed [RW-1:0] v);
`ifdef DCFIR_SAT_EN
    if (v > SAT_MAX) begin
      return {1'b0, {(DW-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return v[DW-1:0];
    end
`else
    return v[DW-1:0];
`endif
  endfunction

  logic [NTAP*CW-1:0]    act_re_s;
  logic [NTAP*CW-1:0]    act_im_s;
  logic signed [DW-1:0]  x_re_q [NTAP];
  logic signed [DW-1:0]  x_re_d [NTAP];
  logic signed [DW-1:0]  x_im_q [NTAP];
  logic signed [DW-1:0]  x_im_d [NTAP];
  logic signed [PW-1:0]  p_rr_q [NTAP];
  logic signed [PW-1:0]  p_rr_d [NTAP];
  logic signed [PW-1:0]  p_ii_q [NTAP];
  logic signed [PW-1:0]  p_ii_d [NTAP];
  logic signed [PW-1:0]  p_ri_q [NTAP];
  logic signed [PW-1:0]  p_ri_d [NTAP];
  logic signed [PW-1:0]  p_ir_q [NTAP];
  logic signed [PW-1:0]  p_ir_d [NTAP];
  logic signed [ACCW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                  v1_q, v2_q, v3_q, dout_valid_q;
  logic [DW-1:0]         out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [CW-1:0]  ar_v, ai_v;
  logic signed [RW-1:0]  rnd_v, sum_re_v, sum_im_v, sh_re_v, sh_im_v;

  dcfir_coe_bank #(.NTAP(NTAP), .CW(CW), .AW(AW)) u_bank (
    .clk         (CLK),
    .rst         (rst),
    .ssb         (ssb),
    .sdi         (sdi),
    .coe_load    (coe_load),
    .coe_pending (coe_pending),
    .active_re   (act_re_s),
    .active_im   (act_im_s)
  );

  // S1 delay line, S2 products from the current active bank, S3 adder tree.
  always_comb begin
    ar_v = '0;
    ai_v = '0;
    if (din_valid) begin
      x_re_d[0] = din_data_real;
      x_im_d[0] = din_data_imag;
    end else begin
      x_re_d[0] = x_re_q[0];
      x_im_d[0] = x_im_q[0];
    end
    for (int k = 1; k < NTAP; k++) begin
      if (din_valid) begin
        x_re_d[k] = x_re_q[k-1];
        x_im_d[k] = x_im_q[k-1];
      end else begin
        x_re_d[k] = x_re_q[k];
        x_im_d[k] = x_im_q[k];
      end
    end
    for (int k = 0; k < NTAP; k++) begin
      ar_v      = act_re_s[k*CW +: CW];
      ai_v      = act_im_s[k*CW +: CW];
      p_rr_d[k] = PW'(ar_v) * PW'(x_re_q[k]);
      p_ii_d[k] = PW'(ai_v) * PW'(x_im_q[k]);
      p_ri_d[k] = PW'(ar_v) * PW'(x_im_q[k]);
      p_ir_d[k] = PW'(ai_v) * PW'(x_re_q[k]);
    end
    acc_re_d = '0;
    acc_im_d = '0;
    for (int k = 0; k < NTAP; k++) begin
      acc_re_d = acc_re_d + ACCW'(p_rr_q[k]) - ACCW'(p_ii_q[k]);
      acc_im_d = acc_im_d + ACCW'(p_ri_q[k]) + ACCW'(p_ir_q[k]);
    end
  end

  // S4 round-half-up, arithmetic shift by sel, then reduce to DW bits.
  always_comb begin
    if (sel == '0) begin
      rnd_v = '0;
    end else begin
      rnd_v = {{(RW-1){1'b0}}, 1'b1} << (sel - SELW'(1));
    end
    sum_re_v = RW'(acc_re_q) + rnd_v;
    sum_im_v = RW'(acc_im_q) + rnd_v;
    if (32'(sel) >= 32'(ACCW)) begin
      sh_re_v = {RW{acc_re_q[ACCW-1]}};
      sh_im_v = {RW{acc_im_q[ACCW-1]}};
    end else begin
      sh_re_v = sum_re_v >>> sel;
      sh_im_v = sum_im_v >>> sel;
    end
    if (v3_q) begin
      out_re_d = reduce_s(sh_re_v);
      out_im_d = reduce_s(sh_im_v);
    end else begin
      out_re_d = out_re_q;
      out_im_d = out_im_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      dout_valid_q <= 1'b0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      out_re_q     <= '0;
      out_im_q     <= '0;
      for (int k = 0; k < NTAP; k++) begin
        x_re_q[k] <= '0;
        x_im_q[k] <= '0;
        p_rr_q[k] <= '0;
        p_ii_q[k] <= '0;
        p_ri_q[k] <= '0;
        p_ir_q[k] <= '0;
      end
    end else begin
      v1_q         <= din_valid;
      v2_q         <= v1_q;
      v3_q         <= v2_q;
      dout_valid_q <= v3_q;
      acc_re_q     <= acc_re_d;
      acc_im_q     <= acc_im_d;
      out_re_q     <= out_re_d;
      out_im_q     <= out_im_d;
      for (int k = 0; k < NTAP; k++) begin
        x_re_q[k] <= x_re_d[k];
        x_im_q[k] <= x_im_d[k];
        p_rr_q[k] <= p_rr_d[k];
        p_ii_q[k] <= p_ii_d[k];
        p_ri_q[k] <= p_ri_d[k];
        p_ir_q[k] <= p_ir_d[k];
      end
    end
  end

  assign dout_valid  = dout_valid_q;
  assign output_real = out_re_q;
  assign output_img  = out_im_q;

endmodule
